// File: rtl/country_sensor_conditioner_pkg.sv
// Shared encodings for the country-road light and the loop sensor conditioner FSM.
package country_sensor_conditioner_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'd0;
  localparam logic [1:0] LIGHT_YELLOW = 2'd1;
  localparam logic [1:0] LIGHT_GREEN  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_SERVE  = 3'd2,
    ST_EXTEND = 3'd3,
    ST_FAULT  = 3'd4
  } sensor_state_t;

  // Code 3 is unused by the controller and reads as not-green, i.e. red.
  function automatic logic is_green(input logic [1:0] light);
    return light == LIGHT_GREEN;
  endfunction

endpackage

// File: rtl/country_sensor_conditioner_debounce.sv
// Loop detector synchroniser and debouncer; emits the clean level plus one-cycle
// arrival/departure pulses aligned with the first cycle of the new level.
module sensor_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic i_clk,
  input  logic i_clear_n,
  input  logic i_loop_raw,
  output logic o_det,
  output logic o_arr,
  output logic o_dep
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_det;
  logic                   r_arr;
  logic                   r_dep;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (!i_clear_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_det  <= 1'b0;
      r_arr  <= 1'b0;
      r_dep  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_loop_raw};
      r_arr  <= 1'b0;
      r_dep  <= 1'b0;
      if (w_sync != r_det) begin
        if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
          r_det <= w_sync;
          r_cnt <= '0;
          r_arr <= w_sync;
          r_dep <= ~w_sync;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_det = r_det;
  assign o_arr = r_arr;
  assign o_dep = r_dep;

endmodule

// File: rtl/country_sensor_conditioner.sv
// Country-road loop conditioner: vehicle queue counter, hold-over timer, stuck-loop
// detection and the request FSM feeding the highway/country light controller.
module country_sensor_conditioner
  import country_sensor_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = 4,
  parameter int HOLD_CYC     = 8,
  parameter int STUCK_CYC    = 4096
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             loop_raw,
  input  logic [1:0]       cntry,
  output logic             x,
  output logic [CNT_W-1:0] veh_count,
  output logic             fault
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int SW = $clog2(STUCK_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_det, w_arr, w_dep;
  logic             w_green, w_demand, w_stuck_hit;
  logic [CNT_W-1:0] r_veh_count;
  logic [SW-1:0]    r_stuck;
  logic [HW-1:0]    r_hold;
  sensor_state_t    r_state;
  logic             r_x;
  logic             r_fault;

  sensor_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .i_clk     (clk),
    .i_clear_n (clear_n),
    .i_loop_raw(loop_raw),
    .o_det     (w_det),
    .o_arr     (w_arr),
    .o_dep     (w_dep)
  );

  assign w_green     = is_green(cntry);
  assign w_demand    = w_det | (r_veh_count != '0);
  assign w_stuck_hit = w_det & (r_stuck == SW'(STUCK_CYC - 1));

  // Stuck timer saturates so the fault keeps re-asserting while the loop stays on.
  always_ff @(posedge clk) begin
    if (!clear_n || !w_det) begin
      r_stuck <= '0;
    end else if (!w_stuck_hit) begin
      r_stuck <= r_stuck + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n || w_stuck_hit) begin
      r_veh_count <= '0;
    end else if (w_arr && !w_green && r_veh_count != CNT_MAX) begin
      r_veh_count <= r_veh_count + CNT_W'(1);
    end else if (w_dep && w_green && r_veh_count != '0) begin
      r_veh_count <= r_veh_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_x     <= 1'b0;
      r_fault <= 1'b0;
    end else if (w_stuck_hit) begin
      r_state <= ST_FAULT;
      r_x     <= 1'b0;
      r_fault <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (w_demand) begin
          r_state <= ST_REQ;
          r_x     <= 1'b1;
        end
        ST_REQ: if (w_green) r_state <= ST_SERVE;
        ST_SERVE: begin
          if (!w_green) begin
            r_state <= w_demand ? ST_REQ : ST_IDLE;
            r_x     <= w_demand;
          end else if (!w_demand) begin
            r_state <= ST_EXTEND;
            r_hold  <= HW'(HOLD_CYC);
          end
        end
        ST_EXTEND: begin
          if (!w_green) begin
            r_state <= w_demand ? ST_REQ : ST_IDLE;
            r_x     <= w_demand;
          end else if (w_demand) begin
            r_state <= ST_SERVE;
          end else if (r_hold == HW'(1)) begin
            r_state <= ST_IDLE;
            r_x     <= 1'b0;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end
        ST_FAULT: if (!w_det) begin
          r_state <= ST_IDLE;
          r_fault <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_x     <= 1'b0;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

  assign x         = r_x;
  assign veh_count = r_veh_count;
  assign fault     = r_fault;

endmodule

// File: tb/tb_country_sensor_conditioner.sv
// Directed plus random stimulus for the country loop conditioner, compared every
// cycle against a behavioural model of the request/count/fault behaviour.
module tb_country_sensor_conditioner;

  localparam int SYNC  = 2;
  localparam int DEB   = 16;
  localparam int CNT_W = 4;
  localparam int HOLD  = 8;
  localparam int STUCK = 64;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clear_n = 1'b0;
  logic             loop_raw = 1'b1;
  logic [1:0]       cntry = 2'd0;
  logic             x;
  logic [CNT_W-1:0] veh_count;
  logic             fault;

  int errors = 0;
  int checks = 0;

  country_sensor_conditioner #(
    .SYNC_STAGES (SYNC),
    .DEBOUNCE_CYC(DEB),
    .CNT_W       (CNT_W),
    .HOLD_CYC    (HOLD),
    .STUCK_CYC   (STUCK)
  ) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .loop_raw (loop_raw),
    .cntry    (cntry),
    .x        (x),
    .veh_count(veh_count),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  // Behavioural model: modes 0 idle, 1 waiting for green, 2 served, 3 hold-over, 4 fault.
  int m_pipe [SYNC];
  int m_det = 0, m_run = 0, m_arr = 0, m_dep = 0;
  int m_cnt = 0, m_mode = 0, m_ext = 0, m_high = 0;
  int nm;
  bit green, demand, stuck;
  logic m_x = 1'b0, m_fault = 1'b0;

  always @(posedge clk) begin : model
    if (!clear_n) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;
      m_det = 0; m_run = 0; m_arr = 0; m_dep = 0;
      m_cnt = 0; m_mode = 0; m_ext = 0; m_high = 0;
    end else begin
      green  = (cntry == 2'd2);
      demand = (m_det != 0) || (m_cnt > 0);
      m_high = m_det ? m_high + 1 : 0;
      stuck  = (m_high >= STUCK);
      nm = m_mode;
      if (stuck) nm = 4;
      else if (m_mode == 0) begin
        if (demand) nm = 1;
      end else if (m_mode == 1) begin
        if (green) nm = 2;
      end else if (m_mode == 4) begin
        if (m_det == 0) nm = 0;
      end else if (!green) begin
        nm = demand ? 1 : 0;
      end else if (demand) begin
        nm = 2;
      end else if (m_mode == 2) begin
        nm = 3; m_ext = 0;
      end else begin
        m_ext++;
        if (m_ext == HOLD) nm = 0;
      end
      if (stuck) m_cnt = 0;
      else if (m_arr != 0 && !green && m_cnt < MAXC) m_cnt++;
      else if (m_dep != 0 && green && m_cnt > 0) m_cnt--;
      m_mode = nm;
      m_arr = 0; m_dep = 0;
      if (m_pipe[SYNC-1] != m_det) begin
        m_run++;
        if (m_run == DEB) begin
          m_det = 1 - m_det;
          m_run = 0;
          if (m_det != 0) m_arr = 1; else m_dep = 1;
        end
      end else m_run = 0;
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = int'(loop_raw);
    end
    m_x     = (m_mode >= 1 && m_mode <= 3);
    m_fault = (m_mode == 4);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("model_x", 32'(x), 32'(m_x));
      chk("model_cnt", 32'(veh_count), 32'(m_cnt));
      chk("model_fault", 32'(fault), 32'(m_fault));
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    loop_raw = 1'b1;
    cyc(hi);
    loop_raw = 1'b0;
    cyc(lo);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int len;
    // Reset with the loop already occupied.
    cyc(3);
    chk("rst_x", 32'(x), 0);
    chk("rst_cnt", 32'(veh_count), 0);
    chk("rst_fault", 32'(fault), 0);
    clear_n = 1'b1;
    cyc(18);
    chk("rel_x_before", 32'(x), 0);
    cyc(1);
    chk("rel_x_at19", 32'(x), 1);
    chk("rel_cnt", 32'(veh_count), 1);

    // Loop held on: det high from edge 18, fault on the 64th det-high cycle (edge 82).
    cyc(62);
    chk("stuck_pre_fault", 32'(fault), 0);
    chk("stuck_pre_x", 32'(x), 1);
    cyc(1);
    chk("stuck_fault", 32'(fault), 1);
    chk("stuck_x", 32'(x), 0);
    chk("stuck_cnt", 32'(veh_count), 0);
    loop_raw = 1'b0;
    cyc(SYNC + DEB - 1);
    chk("stuck_hold", 32'(fault), 1);
    for (int i = 0; i < 2 && fault !== 1'b0; i++) cyc(1);
    chk("stuck_release", 32'(fault), 0);
    chk("stuck_release_x", 32'(x), 0);

    // Short glitch never reaches det.
    cyc(20);
    pulse(10, 30);
    chk("glitch_x", 32'(x), 0);
    chk("glitch_cnt", 32'(veh_count), 0);

    // Three queued vehicles on red, then served on green.
    for (int v = 0; v < 3; v++) pulse(40, 40);
    chk("queue_cnt", 32'(veh_count), 3);
    chk("queue_x", 32'(x), 1);
    cntry = 2'd2;
    cyc(1);
    chk("serve_x", 32'(x), 1);
    pulse(40, 40);
    pulse(40, 40);
    chk("serve_cnt1", 32'(veh_count), 1);
    pulse(40, 0);
    cyc(19);
    chk("drain_cnt", 32'(veh_count), 0);
    chk("drain_x", 32'(x), 1);
    cyc(8);
    chk("hold_last", 32'(x), 1);
    cyc(1);
    chk("hold_drop", 32'(x), 0);
    cyc(12);

    // Saturation on red.
    cntry = 2'd0;
    for (int v = 0; v < 17; v++) pulse(20, 20);
    chk("sat_cnt", 32'(veh_count), MAXC);
    chk("sat_x", 32'(x), 1);

    // Reset mid-operation drops x on the next edge.
    clear_n = 1'b0;
    cyc(1);
    chk("midrst_x", 32'(x), 0);
    chk("midrst_cnt", 32'(veh_count), 0);
    cyc(2);
    clear_n = 1'b1;

    // Random loop activity and light changes, including code 3 and long stuck pulses.
    for (int s = 0; s < 150; s++) begin
      loop_raw = ~loop_raw;
      if ($urandom_range(0, 3) == 0) cntry = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 15) == 0) ? 90 : int'($urandom_range(1, 40));
      cyc(len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
